oam_dma_ctrl: RTL

- Sprite DMA sequencer and bus arbiter between the CPU core and the system bus.
- A CPU write to the DMA register (default $4014) halts the CPU via `cpu_rdy`, then the block takes the bus.
- It copies 256 bytes from page `{page,00}..{page,FF}` to the OAM data port (default $2004), alternating read/write cycles, then returns the bus to the CPU.
- When idle it is a transparent pass-through of CPU address, data and R/nW.

---
 rtl/oam_dma_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/oam_dma_ctrl.sv
// oam_dma_ctrl: sprite DMA sequencer and CPU/system bus arbiter.
// Ports: clk, rst (async, active low), cpu_* in, cpu_rdy out,
// bus_* out, bus_din in, dma_active out; dma_abort in when
// OAM_DMA_ABORT_EN is defined.
`timescale 1ns/1ps

module oam_dma_ctrl #(
  parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004,
  parameter int unsigned XFER_LEN      = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_r_nw,
`ifdef OAM_DMA_ABORT_EN
  input  logic        dma_abort,
`endif
  output logic        cpu_rdy,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_dout,
  output logic        bus_r_nw,
  input  logic [7:0]  bus_din,
  output logic        dma_active
);

  localparam int IW = $clog2(XFER_LEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT_WAIT,
    S_HALT,
    S_ALIGN,
    S_READ,
    S_WRITE
  } state_e;

  state_e        state_q, state_d, cur;
  logic [7:0]    page_q, page_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [7:0]    data_q, data_d;
  logic          parity_q, parity_d;
  logic          cpu_rdy_q, cpu_rdy_d;
  logic          act_q, act_d;
  logic          trig;
  logic          last;
  logic          abort;

`ifdef OAM_DMA_ABORT_EN
  assign abort = dma_abort;
`else
  assign abort = 1'b0;
`endif

  assign trig = !cpu_r_nw && (cpu_addr == DMA_REG_ADDR);
  assign last = (idx_q == IW'(XFER_LEN - 1));

  always_comb begin
    // The CPU's first read while waiting is the halt cycle
    // itself, so it is decoded as HALT in that same cycle.
    cur = state_q;
    if (state_q == S_HALT_WAIT && cpu_r_nw)
      cur = S_HALT;
    state_d  = state_q;
    page_d   = page_q;
    idx_d    = idx_q;
    data_d   = data_q;
    parity_d = ~parity_q;
    unique case (cur)
      S_IDLE: begin
        if (trig) begin
          state_d = S_HALT_WAIT;
          page_d  = cpu_dout;
          idx_d   = '0;
        end
      end
      S_HALT_WAIT: begin
        if (abort)
          state_d = S_IDLE;
        else if (trig)
          page_d = cpu_dout;
      end
      S_HALT: begin
        if (abort)
          state_d = S_IDLE;
        else if (parity_d)
          state_d = S_ALIGN;
        else
          state_d = S_READ;
      end
      S_ALIGN: begin
        state_d = abort ? S_IDLE : S_READ;
      end
      S_READ: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          data_d  = bus_din;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        idx_d   = idx_q + 1'b1;
        state_d = (abort || last) ? S_IDLE : S_READ;
      end
      default: state_d = S_IDLE;
    endcase
    cpu_rdy_d = (state_d == S_IDLE);
    act_d     = (state_d == S_ALIGN) ||
                (state_d == S_READ)  ||
                (state_d == S_WRITE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      page_q    <= '0;
      idx_q     <= '0;
      data_q    <= '0;
      parity_q  <= 1'b0;
      cpu_rdy_q <= 1'b1;
      act_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      page_q    <= page_d;
      idx_q     <= idx_d;
      data_q    <= data_d;
      parity_q  <= parity_d;
      cpu_rdy_q <= cpu_rdy_d;
      act_q     <= act_d;
    end
  end

  always_comb begin
    bus_addr = cpu_addr;
    bus_dout = cpu_dout;
    bus_r_nw = cpu_r_nw;
    unique case (state_q)
      S_ALIGN: begin
        bus_r_nw = 1'b1;
      end
      S_READ: begin
        bus_addr = {page_q, 8'h00} | 16'(idx_q);
        bus_r_nw = 1'b1;
      end
      S_WRITE: begin
        bus_addr = OAM_DATA_ADDR;
        bus_dout = data_q;
        bus_r_nw = 1'b0;
      end
      default: ;
    endcase
  end

  assign cpu_rdy    = cpu_rdy_q;
  assign dma_active = act_q;

endmodule
